serial_word_packer: RTL and testbench

//  Upstream feeder for the 63-bit ones counter. Collects a serial bit stream MSB-first

---
 rtl/serial_word_packer_if.sv | 26 ++
 rtl/serial_word_packer.sv | 88 ++++++++
 tb/tb_serial_word_packer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_packer_if.sv
// rtl/serial_word_packer_if.sv - serial bit in / parallel word out bundle for serial_word_packer
interface serial_word_packer_if #(
    parameter int WIDTH = 63,
    parameter int CNT_W = 6
);
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    // master feeds bits and consumes words; slave is the packer
    modport master (
        output start, sin, sin_valid, word_ready,
        input  word_out, word_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  start, sin, sin_valid, word_ready,
        output word_out, word_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - MSB-first serial-to-parallel framer with valid/ready word output
module serial_word_packer #(
    parameter int WIDTH = 63,
    parameter int CNT_W = 6
) (
    input logic                clk,
    input logic                rst_n,
    serial_word_packer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             busy_q;
    logic             overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                        word_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    // start wins over sin_valid: the restart cycle captures no bit
                    if (bus.start) begin
                        word_q <= '0;
                        cnt_q  <= '0;
                    end else if (bus.sin_valid) begin
                        word_q <= {word_q[WIDTH-2:0], bus.sin};
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state   <= FULL;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    // any bit arriving while the word is parked is lost
                    if (bus.sin_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.word_ready) begin
                        valid_q <= 1'b0;
                        if (bus.start) begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                            word_q <= '0;
                            cnt_q  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - directed table and sequence checks for serial_word_packer
module tb_serial_word_packer;
    localparam int WIDTH = 63;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_word_packer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_word_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] pattern;
        bit               gap;
        logic [WIDTH-1:0] exp_word;
        int               exp_s;
        int               exp_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.word_ready = 1'b0;
    endtask

    // opens a frame and shifts pat MSB-first; returns edges from first bit to word_valid
    task automatic feed_frame(input logic [WIDTH-1:0] pat, input bit gap, output int cyc);
        bus.start = 1'b1;
        bus.sin_valid = 1'b0;
        cycle();
        bus.start = 1'b0;
        check("open_busy", 64'(bus.busy), 64'd1);
        check("open_cnt", 64'(bus.bit_cnt), 64'd0);
        cyc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            bus.sin = pat[WIDTH-1-i];
            bus.sin_valid = 1'b1;
            cycle();
            cyc++;
            if (i == WIDTH - 2) begin
                check("pre_last_valid", 64'(bus.word_valid), 64'd0);
                check("pre_last_cnt", 64'(bus.bit_cnt), 64'(WIDTH - 1));
            end
            if (gap && i != WIDTH - 1) begin
                bus.sin_valid = 1'b0;
                cycle();
                cyc++;
            end
        end
        bus.sin_valid = 1'b0;
        bus.sin = 1'b0;
    endtask

    task automatic check_full(input string tag, input logic [WIDTH-1:0] w, input int s);
        check({tag, "_valid"}, 64'(bus.word_valid), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_cnt"}, 64'(bus.bit_cnt), 64'(WIDTH));
        check({tag, "_word"}, 64'(bus.word_out), 64'(w));
        check({tag, "_S"}, 64'($countones(bus.word_out)), 64'(s));
    endtask

    task automatic handshake(input string tag);
        bus.word_ready = 1'b1;
        cycle();
        bus.word_ready = 1'b0;
        check({tag, "_hs_valid"}, 64'(bus.word_valid), 64'd0);
        check({tag, "_hs_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int               cyc;

        vecs[0] = '{"single_lsb",  63'h0000000000000001, 1'b0, 63'h0000000000000001, 1,  63};
        vecs[1] = '{"all_ones_gap", 63'h7FFFFFFFFFFFFFFF, 1'b1, 63'h7FFFFFFFFFFFFFFF, 63, 125};
        vecs[2] = '{"msb_only",    63'h4000000000000000, 1'b0, 63'h4000000000000000, 1,  63};
        vecs[3] = '{"alt_5",       63'h5555555555555555, 1'b1, 63'h5555555555555555, 32, 125};
        vecs[4] = '{"f71",         63'h0000000000000F71, 1'b0, 63'h0000000000000F71, 8,  63};

        idle_inputs();
        #12;
        check("rst_word", 64'(bus.word_out), 64'd0);
        check("rst_valid", 64'(bus.word_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cnt", 64'(bus.bit_cnt), 64'd0);
        check("rst_ovr", 64'(bus.overrun), 64'd0);
        rst_n = 1'b1;
        cycle();

        // sin_valid in IDLE is ignored
        bus.sin_valid = 1'b1;
        bus.sin = 1'b1;
        cycle();
        idle_inputs();
        check("idle_ign_cnt", 64'(bus.bit_cnt), 64'd0);
        check("idle_ign_busy", 64'(bus.busy), 64'd0);
        check("idle_ign_ovr", 64'(bus.overrun), 64'd0);

        // reset mid-frame discards partial frame
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sin = 1'b1;
            bus.sin_valid = 1'b1;
            cycle();
        end
        idle_inputs();
        check("mid_cnt10", 64'(bus.bit_cnt), 64'd10);
        check("mid_word", 64'(bus.word_out), 64'h3FF);
        rst_n = 1'b0;
        #1;
        check("async_rst_word", 64'(bus.word_out), 64'd0);
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        cycle();
        rst_n = 1'b1;
        check("mid_rst_cnt", 64'(bus.bit_cnt), 64'd0);
        check("mid_rst_valid", 64'(bus.word_valid), 64'd0);
        cycle();
        check("mid_rst_idle", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 5; v++) begin
            feed_frame(vecs[v].pattern, vecs[v].gap, cyc);
            check({vecs[v].name, "_cycles"}, 64'(cyc), 64'(vecs[v].exp_cyc));
            check_full(vecs[v].name, vecs[v].exp_word, vecs[v].exp_s);
            handshake(vecs[v].name);
            check({vecs[v].name, "_held"}, 64'(bus.word_out), 64'(vecs[v].exp_word));
        end

        // FULL stall: 5 cycles no ready, sin pulses on 0,2,4, lone start on 1
        feed_frame(63'h0123456789ABCDEF, 1'b0, cyc);
        held = 63'h0123456789ABCDEF;
        check_full("stall", held, 32);
        for (int i = 0; i < 5; i++) begin
            bus.sin_valid = (i % 2 == 0);
            bus.sin = 1'b1;
            bus.start = (i == 1);
            cycle();
            check("stall_ovr", 64'(bus.overrun), 64'(i % 2 == 0));
            check("stall_word", 64'(bus.word_out), 64'(held));
            check("stall_valid", 64'(bus.word_valid), 64'd1);
            check("stall_busy", 64'(bus.busy), 64'd0);
        end
        idle_inputs();
        cycle();
        check("stall_ovr_end", 64'(bus.overrun), 64'd0);
        handshake("stall");
        check("stall_held", 64'(bus.word_out), 64'(held));

        // restart mid-frame; restart cycle ignores a concurrent bit
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.sin = 1'($urandom_range(0, 1));
            bus.sin_valid = 1'b1;
            cycle();
        end
        check("rs_cnt20", 64'(bus.bit_cnt), 64'd20);
        bus.start = 1'b1;
        bus.sin = 1'b1;
        bus.sin_valid = 1'b1;
        cycle();
        idle_inputs();
        check("rs_cnt0", 64'(bus.bit_cnt), 64'd0);
        check("rs_word0", 64'(bus.word_out), 64'd0);
        check("rs_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < WIDTH; i++) begin
            bus.sin = held[0] ^ held[0] ^ (((63'h0000000000000F71) >> (WIDTH - 1 - i)) & 63'd1) != 0;
            bus.sin_valid = 1'b1;
            cycle();
        end
        idle_inputs();
        check_full("rs", 63'h0000000000000F71, 8);

        // handshake with start in the same cycle goes straight to SHIFT
        bus.word_ready = 1'b1;
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        check("hs_start_busy", 64'(bus.busy), 64'd1);
        check("hs_start_cnt", 64'(bus.bit_cnt), 64'd0);
        check("hs_start_valid", 64'(bus.word_valid), 64'd0);
        check("hs_start_word", 64'(bus.word_out), 64'd0);
        bus.sin = 1'b1;
        bus.sin_valid = 1'b1;
        cycle();
        check("hs_bit1_cnt", 64'(bus.bit_cnt), 64'd1);
        check("hs_bit1_word", 64'(bus.word_out), 64'd1);
        bus.sin = 1'b0;
        for (int i = 1; i < WIDTH; i++) cycle();
        idle_inputs();
        check_full("hs_frame", 63'h4000000000000000, 1);
        handshake("hs_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
